// File: rtl/op_issuer.sv
// rtl/op_issuer.sv - host-side op-word issuer: writes scalar/meta, polls OP_ADDR, returns status
module op_issuer #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int OP_ADDR       = 0,
  parameter int SCALAR_ADDR   = 1,
  parameter int POLL_GAP      = 4,
  parameter int TIMEOUT_POLLS = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_meta,
  input  logic [DATA_WIDTH-1:0] cmd_scalar,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_status,
  output logic [31:0]           resp_cycles,
  output logic                  busy,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata
);

  // op_code lives in the low nibble of the meta word
  localparam logic [3:0] OPC_MAT_ADD      = 4'h1;
  localparam logic [3:0] OPC_MAT_SCAL_MUL = 4'h2;
  localparam logic [3:0] OPC_MAT_SCAL_DIV = 4'h3;
  localparam logic [3:0] OPC_MAT_SCAL_ADD = 4'h4;
  localparam logic [3:0] OPC_MAT_SCAL_INV = 4'h5;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BADOP   = 2'd2;

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [GW-1:0]         GAP_LOAD = GW'(POLL_GAP);
  localparam logic [31:0]           POLL_LIM = 32'(TIMEOUT_POLLS);
  localparam logic [ADDR_WIDTH-1:0] A_OP     = ADDR_WIDTH'(OP_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_SCALAR = ADDR_WIDTH'(SCALAR_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SCALAR,
    S_WR_OP,
    S_GAP,
    S_POLL_RD,
    S_POLL_CHK,
    S_RESP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] meta_q;
  logic [DATA_WIDTH-1:0] scalar_q;
  logic [GW-1:0]         gap_cnt;
  logic [31:0]           poll_cnt;
  logic [31:0]           cycles_q;
  logic [3:0]            cmd_op;
  logic                  is_scalar_op;
  logic                  is_add_op;
  logic                  accept;

  assign cmd_op       = cmd_meta[3:0];
  assign is_scalar_op = (cmd_op == OPC_MAT_SCAL_MUL) || (cmd_op == OPC_MAT_SCAL_DIV) ||
                        (cmd_op == OPC_MAT_SCAL_ADD) || (cmd_op == OPC_MAT_SCAL_INV);
  assign is_add_op    = (cmd_op == OPC_MAT_ADD);
  assign accept       = cmd_valid && cmd_ready;
  assign resp_cycles  = cycles_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Outputs are registered: each branch sets the strobes that belong to the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      meta_q        <= '0;
      scalar_q      <= '0;
      gap_cnt       <= '0;
      poll_cnt      <= '0;
      cycles_q      <= '0;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      resp_status   <= ST_OK;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          if (accept) begin
            meta_q    <= cmd_meta;
            scalar_q  <= cmd_scalar;
            poll_cnt  <= '0;
            cycles_q  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (is_scalar_op) begin
              state         <= S_WR_SCALAR;
              mem_write     <= 1'b1;
              mem_address   <= A_SCALAR;
              mem_writedata <= cmd_scalar;
            end else if (is_add_op) begin
              state         <= S_WR_OP;
              mem_write     <= 1'b1;
              mem_address   <= A_OP;
              mem_writedata <= cmd_meta;
            end else begin
              state       <= S_RESP;
              resp_valid  <= 1'b1;
              resp_status <= ST_BADOP;
            end
          end
        end
        S_WR_SCALAR: begin
          state         <= S_WR_OP;
          mem_write     <= 1'b1;
          mem_address   <= A_OP;
          mem_writedata <= meta_q;
        end
        S_WR_OP: begin
          cycles_q <= sat_inc(cycles_q);
          gap_cnt  <= GAP_LOAD;
          state    <= S_GAP;
        end
        S_GAP: begin
          cycles_q <= sat_inc(cycles_q);
          gap_cnt  <= gap_cnt - GW'(1);
          if (gap_cnt == GW'(1)) begin
            state       <= S_POLL_RD;
            mem_read    <= 1'b1;
            mem_address <= A_OP;
          end
        end
        S_POLL_RD: begin
          cycles_q <= sat_inc(cycles_q);
          poll_cnt <= poll_cnt + 32'd1;
          state    <= S_POLL_CHK;
        end
        S_POLL_CHK: begin
          cycles_q <= sat_inc(cycles_q);
          if (mem_readdata == '0) begin
            state       <= S_RESP;
            resp_valid  <= 1'b1;
            resp_status <= ST_OK;
          end else if ((POLL_LIM != 32'd0) && (poll_cnt == POLL_LIM)) begin
            // op word is left in place; recovery belongs to the host
            state       <= S_RESP;
            resp_valid  <= 1'b1;
            resp_status <= ST_TIMEOUT;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          cmd_ready  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_issuer.sv
// tb/tb_op_issuer.sv - directed bench for op_issuer with a small accelerator memory model
module tb_op_issuer;

  localparam logic [31:0] META_ADD  = 32'h0012_3401;
  localparam logic [31:0] META_MUL  = 32'h00AB_CD02;
  localparam logic [31:0] META_BAD  = 32'h0000_770F;
  localparam logic [31:0] SCAL_MUL  = 32'h4040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, to_cmd_valid;
  logic        cmd_ready, to_cmd_ready;
  logic [31:0] cmd_meta, cmd_scalar;
  logic        resp_valid, to_resp_valid;
  logic        resp_ready, to_resp_ready;
  logic [1:0]  resp_status, to_resp_status;
  logic [31:0] resp_cycles, to_resp_cycles;
  logic        busy, to_busy;
  logic        mem_read, to_mem_read;
  logic        mem_write, to_mem_write;
  logic [9:0]  mem_address, to_mem_address;
  logic [31:0] mem_writedata, to_mem_writedata;
  logic [31:0] mem_readdata = '0, to_mem_readdata = '0;

  op_issuer u_dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_meta(cmd_meta), .cmd_scalar(cmd_scalar),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
    .resp_cycles(resp_cycles), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  op_issuer #(.TIMEOUT_POLLS(2)) u_dut_to (
    .clock(clock), .reset(reset),
    .cmd_valid(to_cmd_valid), .cmd_ready(to_cmd_ready), .cmd_meta(cmd_meta), .cmd_scalar(cmd_scalar),
    .resp_valid(to_resp_valid), .resp_ready(to_resp_ready), .resp_status(to_resp_status),
    .resp_cycles(to_resp_cycles), .busy(to_busy),
    .mem_read(to_mem_read), .mem_write(to_mem_write), .mem_address(to_mem_address),
    .mem_writedata(to_mem_writedata), .mem_readdata(to_mem_readdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  int          cyc = 0;
  wr_t         wr_q[$];
  int          rd_q[$];
  int          both_strobes = 0;
  int          to_reads = 0;
  int          to_op_writes = 0;
  int          rd_base = 0;
  int          clear_after = 0;
  logic [31:0] mem_op = '0;
  logic [31:0] to_op_word = '0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Accelerator model: clears the op word on the clear_after-th poll of the current test.
  always @(posedge clock) begin
    if (mem_write && mem_address == 10'd0) mem_op <= mem_writedata;
    if (mem_read) begin
      if (clear_after != 0 && (rd_q.size() - rd_base) >= clear_after) begin
        mem_readdata <= '0;
        mem_op       <= '0;
      end else begin
        mem_readdata <= mem_op;
      end
    end
    if (to_mem_write && to_mem_address == 10'd0) to_op_word <= to_mem_writedata;
    if (to_mem_read) to_mem_readdata <= to_op_word;
  end

  always @(negedge clock) begin
    if (mem_write) wr_q.push_back('{addr: mem_address, data: mem_writedata, cyc: cyc});
    if (mem_read) rd_q.push_back(cyc);
    if (mem_read && mem_write) both_strobes++;
    if (to_mem_read) to_reads++;
    if (to_mem_write && to_mem_address == 10'd0) to_op_writes++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic issue(input bit to, input logic [31:0] meta, input logic [31:0] sc, output int acc);
    int n = 0;
    @(negedge clock);
    while (!(to ? to_cmd_ready : cmd_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("issue_cmd_ready", to ? to_cmd_ready : cmd_ready, 1);
    cmd_meta   = meta;
    cmd_scalar = sc;
    if (to) to_cmd_valid = 1'b1;
    else cmd_valid = 1'b1;
    acc = cyc;
    @(negedge clock);
    cmd_valid    = 1'b0;
    to_cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit to, input int acc, output int lat);
    int  n = 0;
    bit  seen = 0;
    lat = -1;
    while (!seen && n < 400) begin
      if (to ? to_resp_valid : resp_valid) begin
        lat  = cyc - acc;
        seen = 1;
      end else begin
        @(negedge clock);
        n++;
      end
    end
    if (!seen) chk("resp_wait_expired", 0, 1);
  endtask

  task automatic ack_resp(input bit to);
    if (to) to_resp_ready = 1'b1;
    else resp_ready = 1'b1;
    @(negedge clock);
    resp_ready    = 1'b0;
    to_resp_ready = 1'b0;
    chk("ack_resp_valid_low", to ? to_resp_valid : resp_valid, 0);
    chk("ack_cmd_ready_high", to ? to_cmd_ready : cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lat, w0, r0, t0, t1;
    reset = 1'b0; cmd_valid = 1'b0; to_cmd_valid = 1'b0;
    resp_ready = 1'b0; to_resp_ready = 1'b0; cmd_meta = '0; cmd_scalar = '0;
    repeat (3) @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_strobes", {mem_read, mem_write}, 0);
    chk("rst_resp_cycles", resp_cycles, 0);
    chk("rst_writes", wr_q.size(), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);

    // 1: MAT_ADD, op word already cleared at the first poll
    w0 = wr_q.size(); r0 = rd_q.size(); rd_base = r0; clear_after = 1;
    issue(0, META_ADD, 32'hDEAD_BEEF, acc);
    chk("t1_busy", busy, 1);
    wait_resp(0, acc, lat);
    chk("t1_latency", lat, 8);
    chk("t1_status", resp_status, 0);
    chk("t1_cycles", resp_cycles, 7);
    chk("t1_nwrites", wr_q.size() - w0, 1);
    chk("t1_wr_addr", wr_q[w0].addr, 0);
    chk("t1_wr_data", wr_q[w0].data, META_ADD);
    chk("t1_npolls", rd_q.size() - r0, 1);
    ack_resp(0);

    // 2: MAT_SCAL_MUL writes scalar then meta back to back
    w0 = wr_q.size(); r0 = rd_q.size(); rd_base = r0; clear_after = 1;
    issue(0, META_MUL, SCAL_MUL, acc);
    wait_resp(0, acc, lat);
    chk("t2_latency", lat, 9);
    chk("t2_status", resp_status, 0);
    chk("t2_cycles", resp_cycles, 7);
    chk("t2_nwrites", wr_q.size() - w0, 2);
    chk("t2_wr0_addr", wr_q[w0].addr, 1);
    chk("t2_wr0_data", wr_q[w0].data, SCAL_MUL);
    chk("t2_wr1_addr", wr_q[w0+1].addr, 0);
    chk("t2_wr1_data", wr_q[w0+1].data, META_MUL);
    chk("t2_wr_spacing", wr_q[w0+1].cyc - wr_q[w0].cyc, 1);
    ack_resp(0);

    // 3: cleared on the third poll
    w0 = wr_q.size(); r0 = rd_q.size(); rd_base = r0; clear_after = 3;
    issue(0, META_ADD, 32'h0, acc);
    wait_resp(0, acc, lat);
    chk("t3_npolls", rd_q.size() - r0, 3);
    chk("t3_first_poll", rd_q[r0] - acc, 6);
    chk("t3_poll_gap1", rd_q[r0+1] - rd_q[r0], 6);
    chk("t3_poll_gap2", rd_q[r0+2] - rd_q[r0+1], 6);
    chk("t3_latency", lat, 20);
    chk("t3_status", resp_status, 0);
    chk("t3_cycles", resp_cycles, 19);
    ack_resp(0);

    // 4: TIMEOUT_POLLS=2 and the op word is never cleared
    t0 = to_reads; t1 = to_op_writes;
    issue(1, META_ADD, 32'h0, acc);
    wait_resp(1, acc, lat);
    chk("t4_latency", lat, 14);
    chk("t4_status", to_resp_status, 1);
    chk("t4_cycles", to_resp_cycles, 13);
    chk("t4_npolls", to_reads - t0, 2);
    chk("t4_op_writes", to_op_writes - t1, 1);
    ack_resp(1);

    // 5: unsupported op_code
    w0 = wr_q.size(); r0 = rd_q.size(); rd_base = r0; clear_after = 1;
    issue(0, META_BAD, 32'h1234, acc);
    wait_resp(0, acc, lat);
    chk("t5_latency", lat, 1);
    chk("t5_status", resp_status, 2);
    chk("t5_cycles", resp_cycles, 0);
    chk("t5_strobes", (wr_q.size() - w0) + (rd_q.size() - r0), 0);
    ack_resp(0);

    // 6a: response held while resp_ready stays low
    rd_base = rd_q.size(); clear_after = 1;
    issue(0, META_ADD, 32'h0, acc);
    wait_resp(0, acc, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t6_hold_valid", resp_valid, 1);
      chk("t6_hold_status", resp_status, 0);
      chk("t6_hold_cycles", resp_cycles, 7);
      chk("t6_hold_cmd_ready", cmd_ready, 0);
    end
    ack_resp(0);

    // 6b: reset while in GAP
    rd_base = rd_q.size(); clear_after = 0;
    issue(0, META_ADD, 32'h0, acc);
    repeat (2) @(negedge clock);
    chk("t6_in_gap_busy", busy, 1);
    w0 = wr_q.size();
    reset = 1'b0;
    @(negedge clock);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cmd_ready", cmd_ready, 0);
    chk("t6_rst_resp_valid", resp_valid, 0);
    chk("t6_rst_mem", {mem_read, mem_write, mem_address, mem_writedata}, 0);
    chk("t6_rst_cycles", resp_cycles, 0);
    chk("t6_rst_no_write", wr_q.size() - w0, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_post_cmd_ready", cmd_ready, 1);

    chk("one_strobe_per_cycle", both_strobes, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
